// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder with a pending-request register, valid/ready output and overflow pulse.
// Optional round-robin selection is enabled with the ENC_ROUND_ROBIN_EN macro.
module encoder_8x3_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] D,
    input  logic       RDY,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       V,
    output logic       OVF
);

    // Handshake: {A,B,C} is offered while V=1 and is consumed in any cycle
    // where V=1 and RDY=1; while V=1 and RDY=0 the code and V stay frozen.
    logic [7:0] p_q;
    logic [7:0] s;
    logic [7:0] sel_onehot;
    logic [2:0] code_q;
    logic [2:0] sel;
    logic       sel_found;
    logic       load;
    logic       v_q;
    logic       ovf_q;

    assign s          = p_q | D;
    assign load       = ~v_q | RDY;
    assign sel_found  = |s;
    assign sel_onehot = 8'b0000_0001 << sel;

`ifdef ENC_ROUND_ROBIN_EN
    logic [2:0] lst_q;
    logic [2:0] start;

    assign start = lst_q - 3'd1;

    // Walk from the farthest candidate to the nearest so the nearest set bit
    // below the last grant (wrapping) ends up selected.
    always_comb begin
        sel = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (s[start - 3'(k)]) begin
                sel = start - 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lst_q <= 3'd0;
        end else if (load && sel_found) begin
            lst_q <= sel;
        end
    end
`else
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) begin
                sel = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= 8'd0;
            code_q <= 3'd0;
            v_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= |(D & p_q);
            if (load) begin
                if (sel_found) begin
                    code_q <= sel;
                    v_q    <= 1'b1;
                    p_q    <= s & ~sel_onehot;
                end else begin
                    v_q <= 1'b0;
                    p_q <= 8'd0;
                end
            end else begin
                p_q <= s;
            end
        end
    end

    assign A   = code_q[2];
    assign B   = code_q[1];
    assign C   = code_q[0];
    assign V   = v_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Self-checking bench for encoder_8x3_seq: directed scenarios plus random traffic
// compared against a set-based reference model (follows ENC_ROUND_ROBIN_EN when defined).
module tb_encoder_8x3_seq;

    logic       clk;
    logic       rst;
    logic [7:0] D;
    logic       RDY;
    logic       A;
    logic       B;
    logic       C;
    logic       V;
    logic       OVF;

    int n_checks;
    int n_fails;

    // reference model state
    bit m_pend [8];
    int m_code;
    bit m_v;
    bit m_ovf;
    int m_lst;

    encoder_8x3_seq dut (
        .clk (clk),
        .rst (rst),
        .D   (D),
        .A   (A),
        .B   (B),
        .C   (C),
        .V   (V),
        .RDY (RDY),
        .OVF (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [7:0] d, input logic rdy, input logic r);
        bit s [8];
        bit any_dup;
        int pick;
        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_code = 0;
            m_v    = 1'b0;
            m_ovf  = 1'b0;
            m_lst  = 0;
            return;
        end
        any_dup = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (d[i] && m_pend[i]) any_dup = 1'b1;
            s[i] = m_pend[i] || d[i];
        end
        if (!m_v || rdy) begin
            pick = -1;
`ifdef ENC_ROUND_ROBIN_EN
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (m_lst - k + 16) % 8;
                if (pick < 0 && s[idx]) pick = idx;
            end
`else
            for (int i = 7; i >= 0; i--) begin
                if (pick < 0 && s[i]) pick = i;
            end
`endif
            if (pick >= 0) begin
                m_code = pick;
                m_v    = 1'b1;
                m_lst  = pick;
                for (int i = 0; i < 8; i++) m_pend[i] = s[i] && (i != pick);
            end else begin
                m_v = 1'b0;
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 8; i++) m_pend[i] = s[i];
        end
        m_ovf = any_dup;
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic tick(input string tag, input logic [7:0] d, input logic rdy, input logic r);
        D   = d;
        RDY = rdy;
        rst = r;
        @(posedge clk);
        model_step(d, rdy, r);
        @(negedge clk);
        chk({tag, "_v"}, {7'd0, V}, {7'd0, m_v});
        chk({tag, "_ovf"}, {7'd0, OVF}, {7'd0, m_ovf});
        if (m_v) chk({tag, "_code"}, {5'd0, A, B, C}, 8'(m_code));
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        D   = 8'd0;
        RDY = 1'b0;
        rst = 1'b1;
        model_step(8'd0, 1'b0, 1'b1);
        @(negedge clk);

        // reset state
        tick("reset", 8'hA5, 1'b1, 1'b1);
        chk("reset_code", {5'd0, A, B, C}, 8'd0);

        // single low request
        tick("idle", 8'h00, 1'b1, 1'b0);
        tick("d01_a", 8'h01, 1'b1, 1'b0);
        chk("d01_code", {5'd0, A, B, C}, 8'd0);
        chk("d01_valid", {7'd0, V}, 8'd1);
        tick("d01_b", 8'h00, 1'b1, 1'b0);
        chk("d01_drop", {7'd0, V}, 8'd0);

        // two requests at once, streamed back to back
        tick("d81_a", 8'h81, 1'b1, 1'b0);
        chk("d81_first", {5'd0, A, B, C}, 8'd7);
        tick("d81_b", 8'h00, 1'b1, 1'b0);
        chk("d81_second", {5'd0, A, B, C}, 8'd0);
        tick("d81_c", 8'h00, 1'b1, 1'b0);

        // stall with RDY low
        tick("d10_a", 8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick("d10_hold", 8'h00, 1'b0, 1'b0);
        chk("d10_code", {5'd0, A, B, C}, 8'd4);
        tick("d10_rdy", 8'h00, 1'b1, 1'b0);
        chk("d10_done", {7'd0, V}, 8'd0);

        // duplicate while stalled
        tick("dup_a", 8'h80, 1'b0, 1'b0);
        tick("dup_b", 8'h04, 1'b0, 1'b0);
        tick("dup_c", 8'h04, 1'b0, 1'b0);
        chk("dup_ovf", {7'd0, OVF}, 8'd1);
        tick("dup_d", 8'h00, 1'b0, 1'b0);
        chk("dup_ovf_end", {7'd0, OVF}, 8'd0);
        tick("dup_e", 8'h00, 1'b1, 1'b0);
        chk("dup_code", {5'd0, A, B, C}, 8'd2);
        tick("dup_f", 8'h00, 1'b1, 1'b0);
        chk("dup_once", {7'd0, V}, 8'd0);

        // reset with everything pending
        tick("full_a", 8'hFF, 1'b0, 1'b0);
        tick("full_b", 8'h80, 1'b0, 1'b0);
        tick("full_rst", 8'h00, 1'b1, 1'b1);
        chk("full_rst_code", {5'd0, A, B, C}, 8'd0);
        for (int i = 0; i < 3; i++) tick("full_after", 8'h00, 1'b1, 1'b0);
        chk("full_nothing", {7'd0, V}, 8'd0);

        // continuous 8'h88
        for (int i = 0; i < 6; i++) begin
            tick("d88", 8'h88, 1'b1, 1'b0);
`ifdef ENC_ROUND_ROBIN_EN
            chk("d88_rr", {5'd0, A, B, C}, (i % 2 == 0) ? 8'd7 : 8'd3);
`else
            chk("d88_fixed", {5'd0, A, B, C}, 8'd7);
            if (i >= 1) chk("d88_ovf", {7'd0, OVF}, 8'd1);
`endif
        end
        tick("d88_rst", 8'h00, 1'b1, 1'b1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0] d;
            logic       rdy;
            logic       r;
            d   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1) << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) d = 8'd0;
            rdy = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 60) == 0);
            tick("rand", d, rdy, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
